// File: rtl/demux8_if.sv
// Handshake bus between one upstream producer and eight lane consumers of
// the 1-to-8 demultiplexer. The master side drives the upstream word and
// the per-lane ready bits; the slave side (the demux) drives the rest.
interface demux8_if #(
  parameter int DATA_WIDTH = 64
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [2:0]              in_sel;
  logic [7:0]              out_valid;
  logic [7:0]              out_ready;
  logic [8*DATA_WIDTH-1:0] out_data;
  logic [3:0]              occ;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, occ
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, occ
  );
endinterface

// File: rtl/demux8.sv
// 1-to-8 demultiplexer with one holding register per lane. A word accepted
// on the upstream side lands in lane in_sel one cycle later; each lane
// drains on its own ready, and a lane can drain and refill in one cycle.
// occ is a registered count of occupied lanes.
module demux8 #(
  parameter int DATA_WIDTH = 64
) (
  input  logic      clk,
  input  logic      rst,
  demux8_if.slave   bus
);

  logic [7:0]              vld_p1;
  logic [8*DATA_WIDTH-1:0] data_p1;
  logic [3:0]              occ_p1;
  logic [3:0]              occ_next;
  logic                    in_xfer;
  logic [7:0]              out_xfer;

  // Number of lanes handing a word to their consumer this cycle.
  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) n = n + {3'd0, v[k]};
    return n;
  endfunction

  // Acceptance only looks at the selected lane: empty, or draining now.
  assign bus.in_ready = !vld_p1[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign in_xfer      = bus.in_valid & bus.in_ready;
  assign out_xfer     = vld_p1 & bus.out_ready;

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.occ       = occ_p1;

  // Next occupancy: one in, any number out; stays within 0..8.
  always_comb begin
    occ_next = occ_p1 + {3'd0, in_xfer} - count_ones(out_xfer);
  end

  // Stage p0 -> p1: lane holding registers and occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 8'h00;
      data_p1 <= '0;
      occ_p1  <= 4'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (in_xfer && (bus.in_sel == 3'(i))) begin
          data_p1[i*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
          vld_p1[i] <= 1'b1;
        end else if (out_xfer[i]) begin
          vld_p1[i] <= 1'b0;
        end
      end
      occ_p1 <= occ_next;
    end
  end

endmodule

// File: tb/tb_demux8.sv
// Directed bench for demux8: reset, sweep, fill/backpressure, cross-lane
// independence, drain-and-refill, all-drain and mid-operation reset.
module tb_demux8;

  localparam int DW = 64;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  demux8_if #(.DATA_WIDTH(DW)) bus ();

  demux8 #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] lane(input int i);
    return bus.out_data[i*DW +: DW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = 3'd0;
    bus.out_ready = 8'h00;
    #3;
    chk("rst_out_valid", 64'(bus.out_valid), 64'h00);
    chk("rst_occ", 64'(bus.occ), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_lane0_data", lane(0), 64'd0);

    // Word presented during reset must not be captured
    bus.in_valid = 1'b1;
    bus.in_sel   = 3'd0;
    bus.in_data  = 64'h55;
    tick();
    chk("rst_no_capture_valid", 64'(bus.out_valid), 64'h00);
    chk("rst_no_capture_data", lane(0), 64'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();

    // Sweep: every lane drains immediately
    bus.out_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 3'(i);
      bus.in_data  = 64'(i);
      #1;
      chk("sweep_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      chk("sweep_out_valid", 64'(bus.out_valid), 64'(8'h01 << i));
      chk("sweep_lane_data", lane(i), 64'(i));
      chk("sweep_occ", 64'(bus.occ), 64'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("sweep_end_valid", 64'(bus.out_valid), 64'h00);
    chk("sweep_end_occ", 64'(bus.occ), 64'd0);

    // Fill: no consumer ready
    bus.out_ready = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 3'(i);
      bus.in_data  = 64'h100 + 64'(i);
      tick();
      chk("fill_occ", 64'(bus.occ), 64'(i + 1));
    end
    chk("fill_out_valid", 64'(bus.out_valid), 64'hFF);
    bus.in_sel  = 3'd3;
    bus.in_data = 64'hDEAD;
    #1;
    chk("fill_9th_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    chk("fill_9th_lane3_data", lane(3), 64'h103);
    chk("fill_9th_occ", 64'(bus.occ), 64'd8);
    bus.in_valid = 1'b0;

    // Cross-lane: empty lane 2, lane 5 stays full and stalled
    bus.out_ready = 8'h04;
    tick();
    chk("xlane_drain_valid", 64'(bus.out_valid), 64'hFB);
    chk("xlane_drain_occ", 64'(bus.occ), 64'd7);
    bus.out_ready = 8'h00;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 3'd2;
    bus.in_data   = 64'h222;
    #1;
    chk("xlane_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("xlane_lane2_data", lane(2), 64'h222);
    chk("xlane_lane5_data", lane(5), 64'h105);
    chk("xlane_out_valid", 64'(bus.out_valid), 64'hFF);
    chk("xlane_occ", 64'(bus.occ), 64'd8);
    bus.in_valid = 1'b0;

    // Drain-and-refill on lane 4: first load 0xA
    bus.out_ready = 8'h10;
    tick();
    chk("dr_prep_valid", 64'(bus.out_valid), 64'hEF);
    bus.out_ready = 8'h00;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 3'd4;
    bus.in_data   = 64'hA;
    tick();
    chk("dr_lane4_a", lane(4), 64'hA);
    chk("dr_prep_occ", 64'(bus.occ), 64'd8);
    bus.out_ready = 8'h10;
    bus.in_data   = 64'hB;
    #1;
    chk("dr_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("dr_out_valid", 64'(bus.out_valid), 64'hFF);
    chk("dr_lane4_b", lane(4), 64'hB);
    chk("dr_occ", 64'(bus.occ), 64'd8);
    bus.in_valid = 1'b0;

    // All-drain in a single cycle
    bus.out_ready = 8'hFF;
    tick();
    chk("alldrain_valid", 64'(bus.out_valid), 64'h00);
    chk("alldrain_occ", 64'(bus.occ), 64'd0);
    chk("alldrain_hold_data", lane(4), 64'hB);

    // Reset mid-operation with five lanes full
    bus.out_ready = 8'h00;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 3'(i);
      bus.in_data  = 64'h500 + 64'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("mid_occ5", 64'(bus.occ), 64'd5);
    chk("mid_valid5", 64'(bus.out_valid), 64'h1F);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'h00);
    chk("mid_rst_occ", 64'(bus.occ), 64'd0);
    chk("mid_rst_data", lane(0), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 3'd7;
    bus.in_data  = 64'h777;
    #1;
    chk("post_rst_not_yet", 64'(bus.out_valid), 64'h00);
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_valid", 64'(bus.out_valid), 64'h80);
    chk("post_rst_data", lane(7), 64'h777);
    chk("post_rst_occ", 64'(bus.occ), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
